// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART CSR bank: register word
//               indices, STATUS/IER bit positions and parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_data_w_def  = 8;
    localparam int c_div_w_def   = 16;
    localparam int c_fifo_aw_def = 4;

    typedef logic [3:0] addr_t;

    localparam addr_t c_addr_ctrl   = 4'd0;
    localparam addr_t c_addr_status = 4'd1;
    localparam addr_t c_addr_div    = 4'd2;
    localparam addr_t c_addr_txdata = 4'd3;
    localparam addr_t c_addr_rxdata = 4'd4;
    localparam addr_t c_addr_ier    = 4'd5;
    localparam addr_t c_addr_ipr    = 4'd6;
    localparam addr_t c_addr_thresh = 4'd7;
    localparam addr_t c_addr_level  = 4'd8;

    // Sticky STATUS bits; IER/IPR share the same positions
    localparam int c_st_frame  = 0;
    localparam int c_st_parity = 1;
    localparam int c_st_break  = 2;
    localparam int c_st_tx_ov  = 3;
    localparam int c_st_rx_ov  = 4;
    localparam int c_st_rx_ud  = 5;
    localparam int c_st_n      = 6;
    localparam int c_ie_level  = 6;

    // Live STATUS bits
    localparam int c_st_tx_full  = 6;
    localparam int c_st_rx_full  = 7;
    localparam int c_st_rx_avail = 8;
    localparam int c_st_busy     = 9;

endpackage
`default_nettype wire

// File: rtl/uart_csr_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_csr_bank_if
// Description : Host register bus for the UART CSR bank (strobes, address,
//               write data, registered read data and its valid pulse).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_csr_bank_if;

    logic        wr_i;
    logic        rd_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;

    modport master (
        output wr_i, rd_i, addr_i, wdata_i,
        input  rdata_o, rvalid_o
    );

    modport slave (
        input  wr_i, rd_i, addr_i, wdata_i,
        output rdata_o, rvalid_o
    );

endinterface
`default_nettype wire

// File: rtl/uart_rise_det.sv
`default_nettype none
// ============================================================================
// Module      : uart_rise_det
// Description : Single-flop rising-edge detector; rise_o is high in the cycle
//               d_i is high after having been low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rise_det (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic d_i,
    output logic      rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/uart_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : uart_csr_bank
// Description : Host-visible control/status register bank of a UART: framing
//               config, baud divisor, sticky error flags, FIFO strobes, IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_csr_bank
    import uart_pkg::*;
#(
    parameter int DATA_W  = c_data_w_def,
    parameter int DIV_W   = c_div_w_def,
    parameter int FIFO_AW = c_fifo_aw_def
) (
    input  wire logic                clk_i,
    input  wire logic                rst_i,
    uart_csr_bank_if.slave           bus,
    input  wire logic                frame_err_i,
    input  wire logic                parity_err_i,
    input  wire logic                break_i,
    input  wire logic                rx_overrun_i,
    input  wire logic                tx_full_i,
    input  wire logic                rx_full_i,
    input  wire logic                rx_empty_i,
    input  wire logic                busy_i,
    input  wire logic [FIFO_AW:0]    tx_level_i,
    input  wire logic [FIFO_AW:0]    rx_level_i,
    input  wire logic [DATA_W-1:0]   rx_data_i,
    output logic      [DATA_W-1:0]   tx_data_o,
    output logic                     push_o,
    output logic                     pop_o,
    output logic      [DIV_W-1:0]    divisor_o,
    output logic                     enable_o,
    output logic                     parity_en_o,
    output logic                     even_parity_o,
    output logic                     stop2_o,
    output logic                     irq_o
);

    localparam int LVL_W = FIFO_AW + 1;

    logic [2:0]        ctrl_q,   ctrl_d;
    logic [DIV_W-1:0]  div_q,    div_d;
    logic              enable_q, enable_d;
    logic [5:0]        sticky_q, sticky_d;
    logic [6:0]        ier_q,    ier_d;
    logic [LVL_W-1:0]  thresh_q, thresh_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q,    irq_d;

    logic        w_wr_ctrl, w_wr_status, w_wr_div, w_wr_tx, w_wr_ier, w_wr_thresh;
    logic        w_rd_rx;
    logic        w_brk_rise, w_ovr_rise;
    logic [5:0]  w_set;
    logic [5:0]  w_clr;
    logic [6:0]  w_ipr;
    logic [31:0] w_status;
    logic [31:0] w_rmux;
    logic        w_unused;

    uart_rise_det u_brk_det (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (break_i),
        .rise_o (w_brk_rise)
    );

    uart_rise_det u_ovr_det (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (rx_overrun_i),
        .rise_o (w_ovr_rise)
    );

    assign w_wr_ctrl   = bus.wr_i && (bus.addr_i == c_addr_ctrl);
    assign w_wr_status = bus.wr_i && (bus.addr_i == c_addr_status);
    assign w_wr_div    = bus.wr_i && (bus.addr_i == c_addr_div);
    assign w_wr_tx     = bus.wr_i && (bus.addr_i == c_addr_txdata);
    assign w_wr_ier    = bus.wr_i && (bus.addr_i == c_addr_ier);
    assign w_wr_thresh = bus.wr_i && (bus.addr_i == c_addr_thresh);
    assign w_rd_rx     = bus.rd_i && (bus.addr_i == c_addr_rxdata);

    assign push_o    = w_wr_tx & ~tx_full_i;
    assign pop_o     = w_rd_rx & ~rx_empty_i;
    assign tx_data_o = bus.wdata_i[DATA_W-1:0];

    // Set events for the sticky flags; error flags only latch on a real pop
    always_comb begin
        w_set              = '0;
        w_set[c_st_frame]  = pop_o & frame_err_i;
        w_set[c_st_parity] = pop_o & parity_err_i;
        w_set[c_st_break]  = w_brk_rise;
        w_set[c_st_tx_ov]  = w_wr_tx & tx_full_i;
        w_set[c_st_rx_ov]  = w_ovr_rise;
        w_set[c_st_rx_ud]  = w_rd_rx & rx_empty_i;
    end

    assign w_clr = w_wr_status ? bus.wdata_i[5:0] : 6'b0;
    assign w_ipr = {ier_q[c_ie_level] & (rx_level_i >= thresh_q),
                    sticky_q & ier_q[c_st_n-1:0]};

    always_comb begin
        w_status                = '0;
        w_status[c_st_n-1:0]    = sticky_q;
        w_status[c_st_tx_full]  = tx_full_i;
        w_status[c_st_rx_full]  = rx_full_i;
        w_status[c_st_rx_avail] = ~rx_empty_i;
        w_status[c_st_busy]     = busy_i;
    end

    // Read mux uses current register contents, so a same-cycle write is not seen
    always_comb begin
        w_rmux = '0;
        case (bus.addr_i)
            c_addr_ctrl:   w_rmux[3:1]         = ctrl_q;
            c_addr_status: w_rmux              = w_status;
            c_addr_div:    w_rmux[DIV_W-1:0]   = div_q;
            c_addr_rxdata: if (!rx_empty_i) w_rmux[DATA_W-1:0] = rx_data_i;
            c_addr_ier:    w_rmux[6:0]         = ier_q;
            c_addr_ipr:    w_rmux[6:0]         = w_ipr;
            c_addr_thresh: w_rmux[LVL_W-1:0]   = thresh_q;
            c_addr_level: begin
                w_rmux[16 +: LVL_W] = tx_level_i;
                w_rmux[LVL_W-1:0]   = rx_level_i;
            end
            default:       w_rmux              = '0;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        ier_d    = ier_q;
        thresh_d = thresh_q;
        rdata_d  = rdata_q;
        if (w_wr_ctrl)   ctrl_d   = bus.wdata_i[3:1];
        if (w_wr_div)    div_d    = bus.wdata_i[DIV_W-1:0];
        if (w_wr_ier)    ier_d    = bus.wdata_i[6:0];
        if (w_wr_thresh) thresh_d = bus.wdata_i[LVL_W-1:0];
        if (bus.rd_i)    rdata_d  = w_rmux;
        enable_d = w_wr_div;
        // Set wins over a simultaneous write-1-to-clear
        sticky_d = (sticky_q & ~w_clr) | w_set;
        rvalid_d = bus.rd_i;
        irq_d    = |w_ipr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            div_q    <= '0;
            enable_q <= 1'b0;
            sticky_q <= '0;
            ier_q    <= '0;
            thresh_q <= LVL_W'(1);
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            enable_q <= enable_d;
            sticky_q <= sticky_d;
            ier_q    <= ier_d;
            thresh_q <= thresh_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.rdata_o   = rdata_q;
    assign bus.rvalid_o  = rvalid_q;
    assign divisor_o     = div_q;
    assign enable_o      = enable_q;
    assign parity_en_o   = ctrl_q[0];
    assign even_parity_o = ctrl_q[1];
    assign stop2_o       = ctrl_q[2];
    assign irq_o         = irq_q;

    assign w_unused = ^bus.wdata_i;

endmodule
`default_nettype wire

// File: tb/tb_uart_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_csr_bank
// Description : Directed, table-driven self-checking bench for uart_csr_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_csr_bank;

    logic        clk;
    logic        rst;
    logic        frame_err, parity_err, brk, rx_ovr;
    logic        tx_full, rx_full, rx_empty, busy;
    logic [4:0]  tx_level, rx_level;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        push, pop, enable, parity_en, even_parity, stop2, irq;
    logic [15:0] divisor;

    int n_vec = 0;
    int n_err = 0;

    uart_csr_bank_if bus ();

    uart_csr_bank dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .frame_err_i   (frame_err),
        .parity_err_i  (parity_err),
        .break_i       (brk),
        .rx_overrun_i  (rx_ovr),
        .tx_full_i     (tx_full),
        .rx_full_i     (rx_full),
        .rx_empty_i    (rx_empty),
        .busy_i        (busy),
        .tx_level_i    (tx_level),
        .rx_level_i    (rx_level),
        .rx_data_i     (rx_data),
        .tx_data_o     (tx_data),
        .push_o        (push),
        .pop_o         (pop),
        .divisor_o     (divisor),
        .enable_o      (enable),
        .parity_en_o   (parity_en),
        .even_parity_o (even_parity),
        .stop2_o       (stop2),
        .irq_o         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [4:0]  tx_lvl;
        logic [4:0]  rx_lvl;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input bit w, input logic [3:0] a, input logic [31:0] d,
                           input logic [4:0] tl, input logic [4:0] rl,
                           input logic [31:0] e, input string n);
        vec_t v;
        v.is_wr = w; v.addr = a; v.wdata = d; v.tx_lvl = tl; v.rx_lvl = rl;
        v.exp = e; v.name = n;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
        @(negedge clk);
        bus.wr_i = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        bus.rd_i = 1'b1; bus.addr_i = a;
        @(negedge clk);
        bus.rd_i = 1'b0;
        chk(n, bus.rdata_o, e);
        chk({n, "_rvalid"}, 32'(bus.rvalid_o), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.wr_i = 1'b0; bus.rd_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        frame_err = 0; parity_err = 0; brk = 0; rx_ovr = 0;
        tx_full = 0; rx_full = 0; rx_empty = 1; busy = 0;
        tx_level = '0; rx_level = '0; rx_data = '0;

        add_vec(0, 4'd0, 0, 0, 0, 32'h0,        "rst_ctrl");
        add_vec(0, 4'd1, 0, 0, 0, 32'h0,        "rst_status");
        add_vec(0, 4'd2, 0, 0, 0, 32'h0,        "rst_div");
        add_vec(0, 4'd5, 0, 0, 0, 32'h0,        "rst_ier");
        add_vec(0, 4'd7, 0, 0, 0, 32'h1,        "rst_thresh");
        add_vec(0, 4'd6, 0, 0, 0, 32'h0,        "rst_ipr");
        add_vec(1, 4'd0, 32'hFFFF_FFFF, 0, 0, 0, "");
        add_vec(0, 4'd0, 0, 0, 0, 32'hE,        "ctrl_mask");
        add_vec(1, 4'd2, 32'hABCD_1234, 0, 0, 0, "");
        add_vec(0, 4'd2, 0, 0, 0, 32'h1234,     "div_mask");
        add_vec(1, 4'd5, 32'hFFFF_FFFF, 0, 0, 0, "");
        add_vec(0, 4'd5, 0, 0, 0, 32'h7F,       "ier_mask");
        add_vec(1, 4'd5, 32'h0, 0, 0, 0, "");
        add_vec(1, 4'd7, 32'hFFFF_FFFF, 0, 0, 0, "");
        add_vec(0, 4'd7, 0, 0, 0, 32'h1F,       "thresh_mask");
        add_vec(1, 4'd9, 32'hFFFF_FFFF, 0, 0, 0, "");
        add_vec(0, 4'd9, 0, 0, 0, 32'h0,        "unmapped");
        add_vec(0, 4'd3, 0, 0, 0, 32'h0,        "txdata_wo");
        add_vec(0, 4'd8, 0, 5'd5, 5'd16, 32'h0005_0010, "level");
        add_vec(1, 4'd0, 32'h4, 0, 0, 0, "");
        add_vec(0, 4'd0, 0, 0, 0, 32'h4,        "ctrl_even");

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rvalid",  32'(bus.rvalid_o), 32'd0);
        chk("rst_rdata",   bus.rdata_o, 32'd0);
        chk("rst_enable",  32'(enable), 32'd0);
        chk("rst_irq",     32'(irq), 32'd0);
        chk("rst_divisor", 32'(divisor), 32'd0);

        foreach (vq[i]) begin
            tx_level = vq[i].tx_lvl;
            rx_level = vq[i].rx_lvl;
            if (vq[i].is_wr) do_wr(vq[i].addr, vq[i].wdata);
            else             rd_chk(vq[i].addr, vq[i].exp, vq[i].name);
        end
        tx_level = '0; rx_level = '0;
        chk("framing_outs", {29'd0, stop2, even_parity, parity_en}, 32'h2);

        // Divisor write: update and one-cycle reload pulse, then readback
        @(negedge clk);
        bus.wr_i = 1'b1; bus.addr_i = 4'd2; bus.wdata_i = 32'h0000_0145;
        #1 chk("en_before", 32'(enable), 32'd0);
        @(negedge clk);
        bus.wr_i = 1'b0;
        chk("div_out",  32'(divisor), 32'h145);
        chk("en_pulse", 32'(enable), 32'd1);
        @(negedge clk);
        chk("en_drop",  32'(enable), 32'd0);
        bus.rd_i = 1'b1; bus.addr_i = 4'd2;
        #1 chk("rvalid_pre", 32'(bus.rvalid_o), 32'd0);
        @(negedge clk);
        bus.rd_i = 1'b0;
        chk("div_rd",     bus.rdata_o, 32'h145);
        chk("div_rvalid", 32'(bus.rvalid_o), 32'd1);
        @(negedge clk);
        chk("rvalid_drop", 32'(bus.rvalid_o), 32'd0);
        chk("rdata_hold",  bus.rdata_o, 32'h145);

        // TX push and overflow
        @(negedge clk);
        bus.wr_i = 1'b1; bus.addr_i = 4'd3; bus.wdata_i = 32'h1C3;
        #1 chk("push_ok", 32'(push), 32'd1);
        chk("tx_data", 32'(tx_data), 32'hC3);
        @(negedge clk);
        bus.wr_i = 1'b0; tx_full = 1'b1;
        bus.wr_i = 1'b1; bus.addr_i = 4'd3; bus.wdata_i = 32'h55;
        #1 chk("push_full", 32'(push), 32'd0);
        @(negedge clk);
        bus.wr_i = 1'b0;
        rd_chk(4'd1, 32'h48, "tx_ov_set");
        tx_full = 1'b0;
        do_wr(4'd1, 32'h8);
        rd_chk(4'd1, 32'h0, "tx_ov_clr");

        // RX pop on empty and valid pop with frame error
        rx_data = 8'hA5;
        @(negedge clk);
        bus.rd_i = 1'b1; bus.addr_i = 4'd4;
        #1 chk("pop_empty", 32'(pop), 32'd0);
        @(negedge clk);
        bus.rd_i = 1'b0;
        chk("rx_empty_rd", bus.rdata_o, 32'h0);
        rd_chk(4'd1, 32'h20, "rx_ud_set");
        rx_empty = 1'b0; frame_err = 1'b1; rx_data = 8'h5A;
        @(negedge clk);
        bus.rd_i = 1'b1; bus.addr_i = 4'd4;
        #1 chk("pop_ok", 32'(pop), 32'd1);
        @(negedge clk);
        bus.rd_i = 1'b0; frame_err = 1'b0;
        chk("rx_pop_rd", bus.rdata_o, 32'h5A);
        rd_chk(4'd1, 32'h121, "frame_set");
        rx_empty = 1'b1;
        do_wr(4'd1, 32'h3F);
        rd_chk(4'd1, 32'h0, "all_clr");

        // Level interrupt
        do_wr(4'd5, 32'h40);
        do_wr(4'd7, 32'h3);
        rx_level = 5'd2;
        @(negedge clk);
        chk("irq_below", 32'(irq), 32'd0);
        rx_level = 5'd3;
        #1 chk("irq_same_cycle", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), 32'd1);
        rd_chk(4'd6, 32'h40, "ipr_level");
        rx_level = 5'd2;
        @(negedge clk);
        chk("irq_fall", 32'(irq), 32'd0);

        // Break edge
        @(negedge clk);
        brk = 1'b1;
        rd_chk(4'd1, 32'h4, "break_set");
        do_wr(4'd1, 32'h4);
        rd_chk(4'd1, 32'h0, "break_level_only");
        brk = 1'b0;

        // Overrun held high: edge-only, W1C vs new edge, rd+wr same cycle
        @(negedge clk);
        rx_ovr = 1'b1;
        rd_chk(4'd1, 32'h10, "rx_ov_set");
        do_wr(4'd1, 32'h10);
        rd_chk(4'd1, 32'h0, "rx_ov_level");
        repeat (3) @(negedge clk);
        rx_ovr = 1'b0;
        @(negedge clk);
        rx_ovr = 1'b1;
        bus.wr_i = 1'b1; bus.addr_i = 4'd1; bus.wdata_i = 32'h10;
        @(negedge clk);
        bus.wr_i = 1'b0;
        rd_chk(4'd1, 32'h10, "w1c_vs_edge");
        @(negedge clk);
        bus.rd_i = 1'b1; bus.wr_i = 1'b1; bus.addr_i = 4'd1; bus.wdata_i = 32'h10;
        @(negedge clk);
        bus.rd_i = 1'b0; bus.wr_i = 1'b0;
        chk("rdwr_pre", bus.rdata_o, 32'h10);
        rd_chk(4'd1, 32'h0, "rdwr_post");
        rx_ovr = 1'b0;

        // Reset during a read with irq asserted
        rx_level = 5'd3;
        @(negedge clk);
        @(negedge clk);
        chk("irq_before_rst", 32'(irq), 32'd1);
        bus.rd_i = 1'b1; bus.addr_i = 4'd7; rst = 1'b1;
        @(negedge clk);
        bus.rd_i = 1'b0; rst = 1'b0;
        chk("rst_rd_rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("rst_rd_irq",    32'(irq), 32'd0);
        chk("rst_rd_rdata",  bus.rdata_o, 32'd0);
        rd_chk(4'd7, 32'h1, "thresh_after_rst");
        rd_chk(4'd5, 32'h0, "ier_after_rst");
        chk("irq_after_rst", 32'(irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
